// File: rtl/axi_lite_regbank.sv
// AXI4-Lite register bank: six read/write words, a count of accepted writes
// and a constant ID word. The read and write paths are independent and each
// holds at most one transaction in flight.
module axi_lite_regbank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    s0_axi_aclk,
    input  logic                    s0_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s0_axi_wstrb,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic                    s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic                    s0_axi_rresp,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready
);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [31:0]           ID_VALUE  = 32'hA11C0001;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(8'h1C);

    logic [DATA_WIDTH-1:0]   regs [0:5];
    logic [31:0]             wrcnt;

    logic [0:0]              w_state;
    logic                    aw_held;
    logic                    w_held;
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [3:0]              wstrb_q;

    logic [0:0]              r_state;

    logic                    aw_fire;
    logic                    w_fire;
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [3:0]              wr_strb;
    logic [2:0]              wr_idx;
    logic                    wr_ok;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_err;

    // The top strobe bit has no byte lane behind it.
    logic unused_strb;
    assign unused_strb = &{1'b0, s0_axi_wstrb[DATA_WIDTH/8]};

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && (a <= LAST_ADDR);
    endfunction

    assign s0_axi_awready = (w_state == W_IDLE) && !aw_held;
    assign s0_axi_wready  = (w_state == W_IDLE) && !w_held;
    assign s0_axi_arready = (r_state == R_IDLE);
    assign aw_fire        = s0_axi_awvalid && s0_axi_awready;
    assign w_fire         = s0_axi_wvalid && s0_axi_wready;

    // Merge held and live channel values so a write commits on the edge
    // where its second half arrives.
    always_comb begin
        wr_addr = aw_held ? aw_addr_q : s0_axi_awaddr;
        wr_data = w_held ? wdata_q : s0_axi_wdata;
        wr_strb = w_held ? wstrb_q : s0_axi_wstrb[3:0];
        wr_idx  = wr_addr[4:2];
        commit  = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
        wr_ok   = addr_ok(wr_addr) && (wr_idx < 3'd6);
    end

    // Read mux over the current register contents (pre-write on a commit edge).
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        if (addr_ok(s0_axi_araddr)) begin
            rd_err = 1'b0;
            case (s0_axi_araddr[4:2])
                3'd6:    rd_data = DATA_WIDTH'(wrcnt);
                3'd7:    rd_data = DATA_WIDTH'(ID_VALUE);
                default: rd_data = regs[s0_axi_araddr[4:2]];
            endcase
        end
    end

    // Write path: capture AW/W independently, commit, then hold the response.
    always_ff @(posedge s0_axi_aclk) begin
        if (!s0_axi_aresetn) begin
            w_state       <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr_q     <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            s0_axi_bvalid <= 1'b0;
            s0_axi_bresp  <= 1'b0;
            wrcnt         <= '0;
            for (int r = 0; r < 6; r++) begin
                regs[r] <= '0;
            end
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (commit) begin
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        s0_axi_bvalid <= 1'b1;
                        s0_axi_bresp  <= !wr_ok;
                        w_state       <= W_RESP;
                        if (wr_ok) begin
                            for (int i = 0; i < DATA_WIDTH/8; i++) begin
                                if (wr_strb[i]) begin
                                    regs[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                                end
                            end
                            wrcnt <= wrcnt + 32'd1;
                        end
                    end else begin
                        if (aw_fire) begin
                            aw_held   <= 1'b1;
                            aw_addr_q <= s0_axi_awaddr;
                        end
                        if (w_fire) begin
                            w_held  <= 1'b1;
                            wdata_q <= s0_axi_wdata;
                            wstrb_q <= s0_axi_wstrb[3:0];
                        end
                    end
                end
                W_RESP: begin
                    if (s0_axi_bready) begin
                        s0_axi_bvalid <= 1'b0;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read path: register the looked-up word and hold it until accepted.
    always_ff @(posedge s0_axi_aclk) begin
        if (!s0_axi_aresetn) begin
            r_state       <= R_IDLE;
            s0_axi_rvalid <= 1'b0;
            s0_axi_rresp  <= 1'b0;
            s0_axi_rdata  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s0_axi_arvalid) begin
                        s0_axi_rdata  <= rd_data;
                        s0_axi_rresp  <= rd_err;
                        s0_axi_rvalid <= 1'b1;
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s0_axi_rready) begin
                        s0_axi_rvalid <= 1'b0;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_lite_regbank.md
AXI_LITE_REGBANK -- requirements
Module: axi_lite_regbank

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: data bus width; only 32 is supported.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8: byte address width.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset: s0_axi_aclk  input  1  clock; s0_axi_aresetn  input  1  reset, sampled only on the rising edge of s0_axi_aclk.
REQ-004 s0_axi_awaddr  input  ADDR_WIDTH  write byte address.
REQ-005 s0_axi_awvalid  input  1; s0_axi_awready  output  1.
REQ-006 s0_axi_wdata  input  DATA_WIDTH  write data.
REQ-007 s0_axi_wstrb  input  DATA_WIDTH/8+1  byte strobes; bits [3:0] are used and bit 4 is ignored.
REQ-008 s0_axi_wvalid  input  1; s0_axi_wready  output  1.
REQ-009 s0_axi_bresp  output  1  write response: 0 = OKAY, 1 = error.
REQ-010 s0_axi_bvalid  output  1; s0_axi_bready  input  1.
REQ-011 s0_axi_araddr  input  ADDR_WIDTH; s0_axi_arvalid  input  1; s0_axi_arready  output  1.
REQ-012 s0_axi_rdata  output  DATA_WIDTH; s0_axi_rresp  output  1 (0 = OKAY, 1 = error); s0_axi_rvalid  output  1; s0_axi_rready  input  1.

Function
REQ-013 The register map SHALL be eight 32-bit words: 0x00–0x14 REG0–REG5 (read/write); 0x18 WRCNT (read-only); 0x1C ID (read-only, constant 0xA11C0001).
REQ-014 An address SHALL be valid only if addr[1:0]==0 and addr<=0x1C; any other address is invalid.
REQ-015 Write FSM states SHALL be W_IDLE and W_RESP.
REQ-016 In W_IDLE, awready and wready SHALL each be 1 until that channel's handshake completes; address and data are captured independently, in any order or in the same cycle.
REQ-017 In the cycle both are captured, the write SHALL commit at that clock edge; the FSM then enters W_RESP with bvalid=1 on the next cycle, giving 1-cycle latency when AW and W arrive together.
REQ-018 In W_RESP, awready and wready SHALL be 0, and bvalid and bresp SHALL hold stable until bready=1; the FSM then returns to W_IDLE.
REQ-019 A write to REG0–REG5 SHALL update only the bytes with wstrb[i]=1, return bresp=0, and increment WRCNT; an all-zero strobe still returns OKAY and increments WRCNT.
REQ-020 A write to WRCNT, to ID, or to an invalid address SHALL change no storage and return bresp=1, and WRCNT SHALL not increment.
REQ-021 WRCNT SHALL be 32 bits and wrap from 0xFFFFFFFF to 0x00000000.
REQ-022 Read FSM states SHALL be R_IDLE (arready=1) and R_DATA (arready=0, rvalid=1).
REQ-023 On an AR handshake, rdata and rresp SHALL be registered and rvalid SHALL be 1 on the next cycle; they hold stable until rready=1, then the FSM returns to R_IDLE.
REQ-024 A read of an invalid address SHALL return rdata=0 and rresp=1; any valid address returns rresp=0.
REQ-025 Read and write channels SHALL operate concurrently; an AR handshake in the same cycle as a write commit to the same word returns the pre-write value.
REQ-026 While rvalid=1, rdata SHALL not change, even if a write commits to the word being read.
REQ-027 The read and write paths SHALL each accept at most one outstanding transaction.

Reset
REQ-028 When s0_axi_aresetn=0 at a rising edge, the block SHALL set REG0–REG5=0, WRCNT=0, both FSMs to idle, awready=wready=arready=1 from the next cycle, and bvalid=rvalid=0, bresp=rresp=0, rdata=0.
REQ-029 A reset asserted mid-transaction SHALL abort that transaction with no response issued; a half-captured AW or W is discarded and a pending write does not commit.

Verification
REQ-030 The bench SHALL drive AW=0x04 and W=0x00000017 with wstrb=0xF in the same cycle -> bvalid=1 with bresp=0 on the next cycle; a read of 0x04 returns 0x00000017 with rresp=0; a read of 0x18 returns 1.
REQ-031 The bench SHALL drive W=0x11223344 three cycles before AW=0x10 -> wready drops after the W handshake, the write commits on the AW handshake, and REG4=0x11223344.
REQ-032 The bench SHALL write REG0=0xFFFFFFFF, then write 0x00000000 with wstrb=0x5 -> REG0=0xFF00FF00.
REQ-033 The bench SHALL write to 0x1C, to 0x02 and to 0x40 -> bresp=1 each time, ID and WRCNT are unchanged; reads of 0x02 and 0x40 return rdata=0 with rresp=1; a read of 0x1C returns 0xA11C0001.
REQ-034 The bench SHALL hold bready=0 and rready=0 for five cycles -> bvalid, bresp, rvalid and rdata stay constant, awready=wready=arready=0, and a write to the word being read does not alter rdata.
REQ-035 The bench SHALL assert reset while bvalid=1 and REG1=0x5 -> on the next cycle bvalid=0, REG1=0 and WRCNT=0.
